// File: rtl/servo_pkg.sv
// Shared definitions for the servo slew controller.
// Build option: define SERVO_SLEW_EN to rate-limit duty changes to STEP per
// frame; left undefined, duty jumps straight to its target at the boundary.
package servo_pkg;

  typedef enum logic [1:0] {
    OP_CENTER = 2'b00,
    OP_MAX    = 2'b01,
    OP_MIN    = 2'b10,
    OP_ABS    = 2'b11
  } cmd_op_e;

  localparam int DEF_PERIOD   = 2000000;
  localparam int DEF_DUTY_MIN = 100000;
  localparam int DEF_DUTY_MAX = 200000;
  localparam int DEF_DUTY_CTR = 150000;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: holds target and duty, steps duty toward target at each
// frame boundary by at most STEP, and pulses done when a step lands on target.
module servo_slew_ch #(
  parameter int DW       = 21,
  parameter int DUTY_CTR = 150000,
  parameter int STEP     = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [DW-1:0] tgt_i,
  input  logic          bnd_i,
  output logic [DW-1:0] duty_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [DW-1:0] STEP_W = DW'(STEP);
  localparam logic [DW-1:0] CTR_W  = DW'(DUTY_CTR);

  logic [DW-1:0] tgt_q, tgt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          done_q, done_d;
  logic [DW-1:0] up, dn;

  // Next target (last writer wins) and the boundary step, which reads the
  // target held before this cycle's command lands.
  always_comb begin
    tgt_d  = wr_i ? tgt_i : tgt_q;
    up     = tgt_q - duty_q;
    dn     = duty_q - tgt_q;
    duty_d = duty_q;
    if (bnd_i) begin
      if (tgt_q > duty_q)      duty_d = (up > STEP_W) ? duty_q + STEP_W : tgt_q;
      else if (tgt_q < duty_q) duty_d = (dn > STEP_W) ? duty_q - STEP_W : tgt_q;
    end
    done_d = bnd_i && (duty_q != tgt_q) && (duty_d == tgt_q);
  end

  // Channel state; reset parks everything at centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q  <= CTR_W;
      duty_q <= CTR_W;
      done_q <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      duty_q <= duty_d;
      done_q <= done_d;
    end
  end

  assign duty_o = duty_q;
  assign busy_o = (duty_q != tgt_q);
  assign done_o = done_q;

endmodule

// File: rtl/servo_slew_ctrl.sv
// Multi-channel servo PWM generator with per-frame duty slewing.
// Build option SERVO_SLEW_EN (see servo_pkg) selects ramping vs. jumping.
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DUTY_MIN = DEF_DUTY_MIN,
  parameter int DUTY_MAX = DEF_DUTY_MAX,
  parameter int DUTY_CTR = DEF_DUTY_CTR,
  parameter int STEP     = 1000,
  parameter int DW       = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(NUM_CH)-1:0]  cmd_ch,
  input  logic [1:0]                 cmd_op,
  input  logic [DW-1:0]              cmd_pos,
  output logic [NUM_CH*DW-1:0]       s_duty,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          done,
  output logic                       frame_start,
  output logic [NUM_CH-1:0]          SERVO
);

  localparam int CHW = $clog2(NUM_CH);
  // Without slewing, a step as wide as the legal range always lands on target.
  localparam int CH_STEP = SLEW_EN ? STEP : (DUTY_MAX - DUTY_MIN);
  localparam logic [DW-1:0] LAST_W = DW'(PERIOD - 1);
  localparam logic [DW-1:0] MIN_W  = DW'(DUTY_MIN);
  localparam logic [DW-1:0] MAX_W  = DW'(DUTY_MAX);
  localparam logic [DW-1:0] CTR_W  = DW'(DUTY_CTR);

  logic [DW-1:0]               cnt_q, cnt_d;
  logic                        fs_q;
  logic                        bnd, acc;
  cmd_op_e                     op;
  logic [DW-1:0]               tgt_new;
  logic [NUM_CH-1:0][DW-1:0]   duty_w;
  logic [NUM_CH-1:0]           servo_q, servo_d;

  assign bnd       = (cnt_q == LAST_W);
  assign cmd_ready = ~rst;
  assign acc       = cmd_valid & ~rst;
  assign op        = cmd_op_e'(cmd_op);

  // Frame counter wraps after PERIOD-1.
  always_comb cnt_d = bnd ? '0 : cnt_q + DW'(1);

  // Command decode: map opcode to a target, clamping absolute positions.
  always_comb begin
    tgt_new = CTR_W;
    case (op)
      OP_CENTER: tgt_new = CTR_W;
      OP_MAX:    tgt_new = MAX_W;
      OP_MIN:    tgt_new = MIN_W;
      OP_ABS:    tgt_new = (cmd_pos < MIN_W) ? MIN_W :
                           (cmd_pos > MAX_W) ? MAX_W : cmd_pos;
      default:   tgt_new = CTR_W;
    endcase
  end

  // PWM compare, registered so outputs are glitch-free.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) servo_d[i] = (cnt_q < duty_w[i]);
  end

  // Counter, frame pulse and PWM output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      fs_q    <= 1'b0;
      servo_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      fs_q    <= bnd;
      servo_q <= servo_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew_ch #(
      .DW       (DW),
      .DUTY_CTR (DUTY_CTR),
      .STEP     (CH_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr_i   (acc && (cmd_ch == CHW'(i))),
      .tgt_i  (tgt_new),
      .bnd_i  (bnd),
      .duty_o (duty_w[i]),
      .busy_o (busy[i]),
      .done_o (done[i])
    );
  end

  assign s_duty      = duty_w;
  assign frame_start = fs_q;
  assign SERVO       = servo_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl: continuous comparison against a frame-level
// model, a table of command/settled-duty vectors, directed corner sequences
// and a randomized command phase.
module tb_servo_slew_ctrl;
  localparam int NUM_CH = 4, PERIOD = 1000, DMIN = 100, DMAX = 200, DCTR = 150;
  localparam int STEP = 20, DW = 11;
  localparam logic [1:0] OPC = 2'b00, OPX = 2'b01, OPN = 2'b10, OPA = 2'b11;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic cmd_ready, frame_start;
  logic [1:0] cmd_ch = '0, cmd_op = '0;
  logic [DW-1:0] cmd_pos = '0;
  logic [NUM_CH*DW-1:0] s_duty;
  logic [NUM_CH-1:0] busy, done, SERVO;

  always #5 clk = ~clk;

  servo_slew_ctrl #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX),
                    .DUTY_CTR(DCTR), .STEP(STEP), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_op(cmd_op), .cmd_pos(cmd_pos), .s_duty(s_duty), .busy(busy), .done(done),
    .frame_start(frame_start), .SERVO(SERVO));

  // ---------------- reference model (frame-level rules) ----------------
  int m_cnt;
  int m_duty [NUM_CH];
  int m_tgt  [NUM_CH];
  logic [NUM_CH-1:0] m_servo, m_done;
  logic m_fs;

  function automatic int target_of(logic [1:0] op, int pos);
    case (op)
      OPC: return DCTR;
      OPX: return DMAX;
      OPN: return DMIN;
      default: return (pos < DMIN) ? DMIN : (pos > DMAX) ? DMAX : pos;
    endcase
  endfunction

  function automatic int approach(int d, int t);
`ifdef SERVO_SLEW_EN
    if (t > d) return (t - d > STEP) ? d + STEP : t;
    if (t < d) return (d - t > STEP) ? d - STEP : t;
    return d;
`else
    return t;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_servo = '0; m_done = '0; m_fs = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = DCTR; m_tgt[i] = DCTR; end
    end else begin
      for (int i = 0; i < NUM_CH; i++) m_servo[i] = (m_cnt < m_duty[i]);
      m_fs = (m_cnt == PERIOD - 1);
      m_done = '0;
      if (m_fs)
        for (int i = 0; i < NUM_CH; i++)
          if (m_duty[i] != m_tgt[i]) begin
            m_duty[i] = approach(m_duty[i], m_tgt[i]);
            m_done[i] = (m_duty[i] == m_tgt[i]);
          end
      if (cmd_valid && int'(cmd_ch) < NUM_CH) m_tgt[cmd_ch] = target_of(cmd_op, int'(cmd_pos));
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0, n_err = 0;
  int done_cnt [NUM_CH];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all();
    logic [NUM_CH*DW-1:0] ed;
    logic [NUM_CH-1:0] eb;
    for (int i = 0; i < NUM_CH; i++) begin
      ed[i*DW +: DW] = DW'(m_duty[i]);
      eb[i] = (m_duty[i] != m_tgt[i]);
    end
    chk("cmd_ready", cmd_ready, !rst);
    chk("s_duty", s_duty, ed);
    chk("busy", busy, eb);
    chk("done", done, m_done);
    chk("frame_start", frame_start, m_fs);
    chk("SERVO", SERVO, m_servo);
  endtask

  task automatic tick();
    @(negedge clk);
    chk_all();
    for (int i = 0; i < NUM_CH; i++) done_cnt[i] += int'(done[i]);
  endtask

  function automatic int duty(int ch);
    return int'(s_duty[ch*DW +: DW]);
  endfunction

  // Advance to the cycle in which the counter reads PERIOD-1.
  task automatic wait_last();
    int k = 0;
    while (m_cnt != PERIOD - 1 && k < PERIOD + 2) begin tick(); k++; end
    chk("wait_last", m_cnt, PERIOD - 1);
  endtask

  // Advance past the next boundary update.
  task automatic wait_bnd();
    wait_last();
    tick();
  endtask

  task automatic issue(int ch, logic [1:0] op, int pos);
    cmd_ch = 2'(ch); cmd_op = op; cmd_pos = DW'(pos); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic settle(int ch);
    int k = 0;
    while (busy[ch] && k < 7 * PERIOD) begin tick(); k++; end
    chk("settle_busy", busy[ch], 1'b0);
  endtask

  typedef struct { int ch; logic [1:0] op; int pos; int exp; } vec_t;
  vec_t tbl [8];
  int hi [NUM_CH];
  int d0, e1, e2;
  int exp3 [3];

  initial begin
    for (int i = 0; i < NUM_CH; i++) done_cnt[i] = 0;
    tbl[0] = '{2, OPA, 500, 200};
    tbl[1] = '{2, OPA, 50, 100};
    tbl[2] = '{0, OPA, 130, 130};
    tbl[3] = '{1, OPC, 0, 150};
    tbl[4] = '{3, OPX, 0, 200};
    tbl[5] = '{3, OPN, 0, 100};
    tbl[6] = '{0, OPA, 100, 100};
    tbl[7] = '{1, OPA, 201, 200};
`ifdef SERVO_SLEW_EN
    exp3 = '{170, 190, 200}; e1 = 170;
`else
    exp3 = '{200, 200, 200}; e1 = 200;
`endif

    // Reset state, then a full idle frame at centre.
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    repeat (PERIOD) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(SERVO[i]);
    end
    for (int i = 0; i < NUM_CH; i++) chk("hi_after_reset", hi[i], DCTR);
    chk("busy_idle", busy, 0);
    chk("done_idle", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 0);

    // MAX on ch1: three boundaries, one done pulse, others untouched.
    d0 = done_cnt[1];
    issue(1, OPX, 0);
    for (int k = 0; k < 3; k++) begin
      wait_bnd();
      chk("max_ch1_ramp", duty(1), exp3[k]);
      chk("ch0_still_ctr", duty(0), DCTR);
      chk("ch3_still_ctr", duty(3), DCTR);
    end
    wait_bnd();
    chk("done1_once", done_cnt[1] - d0, 1);

    // MAX on ch0: first boundary jumps (no slew) or steps (slew).
    d0 = done_cnt[0];
    issue(0, OPX, 0);
    wait_bnd();
    chk("max_ch0_first", duty(0), e1);
    settle(0);
    wait_bnd();
    chk("done0_once", done_cnt[0] - d0, 1);

    // MIN issued on the boundary cycle: that boundary uses the old target.
    issue(3, OPX, 0);
    wait_bnd();
    chk("ch3_pre", duty(3), e1);
    wait_last();
    issue(3, OPN, 0);
`ifdef SERVO_SLEW_EN
    e2 = 190;
`else
    e2 = 200;
`endif
    chk("min_on_bnd_old", duty(3), e2);
    wait_bnd();
`ifdef SERVO_SLEW_EN
    e2 = 170;
`else
    e2 = 100;
`endif
    chk("min_next_bnd", duty(3), e2);

    // Reset mid-ramp on ch2.
    issue(2, OPX, 0);
    wait_bnd();
    chk("ch2_mid_ramp", duty(2), e1);
    repeat (300) tick();
    rst = 1'b1;
    #1;
    chk("rst_servo", SERVO, 0);
    chk("rst_done", done, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_duty2", duty(2), DCTR);
    repeat (4) tick();
    rst = 1'b0;
    hi[2] = 0;
    repeat (PERIOD) begin tick(); hi[2] += int'(SERVO[2]); end
    chk("hi_after_midramp_rst", hi[2], DCTR);

    // Table: command then settled duty.
    foreach (tbl[n]) begin
      issue(tbl[n].ch, tbl[n].op, tbl[n].pos);
      settle(tbl[n].ch);
      chk("tbl_settled", duty(tbl[n].ch), tbl[n].exp);
    end

    // Randomized commands; the model checks every cycle.
    repeat (15000) begin
      if ($urandom_range(0, 39) == 0) begin
        cmd_ch = 2'($urandom_range(0, NUM_CH - 1));
        cmd_op = 2'($urandom_range(0, 3));
        cmd_pos = DW'($urandom_range(0, 400));
        cmd_valid = 1'b1;
      end else cmd_valid = 1'b0;
      tick();
    end
    cmd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
